booth_mult_n: RTL and testbench
===============================

BOOTH_MULT_N -- requirements
Module: booth_mult_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is 4..32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port enable, input, 1 bit: start request, sampled only in IDLE.
REQ-005 SHALL have port is_signed, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled together with enable.
REQ-006 SHALL have port inbus, input, WIDTH bits: shared operand bus carrying the multiplicand M, then the multiplier Q.
REQ-007 SHALL have port ready, output, 1 bit: high only in IDLE.
REQ-008 SHALL have port out_valid, output, 1 bit: a product beat is present on outbus.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the beat.
REQ-010 SHALL have port out_hi, output, 1 bit: 1 = current beat is the high half, 0 = the low half.
REQ-011 SHALL have port outbus, output, WIDTH bits: product beat; all zeros whenever out_valid is low (no internal tri-states).
REQ-012 SHALL have port done, output, 1 bit: one-cycle registered pulse marking completion.

Function
REQ-013 SHALL implement states IDLE, LOAD_Q, RUN, OUT_HI and OUT_LO as a registered FSM.
REQ-014 IDLE with enable=1: SHALL capture inbus into M (WIDTH+1 bits, sign-extended if is_signed, else zero-extended), latch is_signed, and go to LOAD_Q.
REQ-015 LOAD_Q: SHALL capture inbus into Q (extended to WIDTH+1 bits by the latched mode), clear A (WIDTH+1 bits), Qm and the iteration counter, and go to RUN unconditionally.
REQ-016 RUN, each cycle, SHALL select sum by {Q[0],Qm}: A+M if 01, A-M (A + ~M + 1) if 10, else A.
REQ-017 RUN, same cycle, SHALL arithmetic-shift {sum,Q,Qm} right by one and increment the counter.
REQ-018 RUN SHALL last exactly WIDTH+1 cycles, then go to OUT_HI; the counter is $clog2(WIDTH+2) bits wide.
REQ-019 SHALL take the product as the low 2*WIDTH bits of {A,Q[WIDTH:0]}, shifted so that P = M*Q exactly, for both modes.
REQ-020 OUT_HI SHALL drive out_valid=1, out_hi=1 and outbus=P[2W-1:W]; on out_ready=1 it goes to OUT_LO.
REQ-021 OUT_LO SHALL drive out_valid=1, out_hi=0 and outbus=P[W-1:0]; on out_ready=1 it goes to IDLE and sets done for the next cycle only.
REQ-022 Latency SHALL be fixed: the first out_valid appears WIDTH+3 cycles after the enable cycle.
REQ-023 Backpressure: SHALL hold outbus and out_hi stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-024 With out_ready held at 1, the two beats SHALL occur on consecutive cycles.
REQ-025 SHALL ignore enable, inbus and is_signed outside IDLE and LOAD_Q; they have no effect on the running result.
REQ-026 done and enable in the same IDLE cycle SHALL both be honoured: the pulse occurs and the new operation starts.
REQ-027 Arithmetic SHALL wrap modulo 2^(WIDTH+1) internally and SHALL NOT raise any overflow indication.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, with no clock required.
REQ-029 rst_n=0 SHALL clear A, Q, Qm, M and the counter to 0.
REQ-030 rst_n=0 SHALL force out_valid=0, out_hi=0, outbus=0, done=0 and ready=1.
REQ-031 Reset asserted mid-operation SHALL abandon the operation with no beat ever emitted for it.
REQ-032 After rst_n deasserts, the block SHALL accept enable on the first rising clock edge.

Verification
REQ-033 WIDTH=8, signed, M=0xFD (-3), Q=0x05 -> beats 0xFF (hi) then 0xF1 (lo); first out_valid 11 cycles after enable.
REQ-034 WIDTH=8, unsigned, M=0xFF, Q=0xFF -> beats 0xFE then 0x01; signed M=0x80, Q=0x80 -> 0x40 then 0x00.
REQ-035 WIDTH=16, signed, M=0x8000, Q=0x7FFF -> beats 0xC000 then 0x8000.
REQ-036 WIDTH=8, 3*7 with out_ready=0 for 5 cycles in OUT_HI -> outbus holds 0x00 with out_hi=1; then 0x00 and 0x15 on consecutive cycles; done pulses once.
REQ-037 Reset asserted in RUN cycle 4, then a new 2*2 -> no beat from the aborted run; new result 0x00, 0x04.
REQ-038 enable toggled and inbus randomised during RUN -> result unchanged from the captured operands; ready=0 throughout.

Source files
------------

// File: rtl/booth_mult_n.sv
// booth_mult_n: sequential radix-2 Booth multiplier with a shared operand bus
// and a two-beat product output (high half first, then low half).
//
// Operands are held internally as WIDTH+1 bits. Signed operands are
// sign-extended and unsigned operands are zero-extended. This lets one Booth
// datapath handle both modes, and keeps M away from the most-negative
// WIDTH+1-bit value that would break the subtract step.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   enable     start request, sampled only in IDLE
//   is_signed  operand mode, sampled with enable
//   inbus      multiplicand M (IDLE cycle), then multiplier Q (LOAD_Q cycle)
//   ready      high only in IDLE
//   out_valid  a product beat is on outbus
//   out_ready  consumer accepts the current beat
//   out_hi     1 = high half of the product, 0 = low half
//   outbus     product beat, zero when out_valid is low
//   done       one-cycle pulse after the low beat is accepted
module booth_mult_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] inbus,
    output logic             ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_hi,
    output logic [WIDTH-1:0] outbus,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_Q = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_OUT_HI = 3'd3;
    localparam logic [2:0] S_OUT_LO = 3'd4;

    localparam logic [WIDTH:0] ONE      = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH);

    logic [2:0]     state_reg;
    logic [WIDTH:0] m_reg;
    logic [WIDTH:0] a_reg;
    logic [WIDTH:0] q_reg;
    logic           qm_reg;
    logic [CW-1:0]  cnt_reg;
    logic           sgn_reg;
    logic           done_reg;

    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] sum;
    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;

    // M uses the live mode bit because it is captured in the same cycle as
    // is_signed; Q uses the latched mode.
    assign m_ext = {is_signed & inbus[WIDTH-1], inbus};
    assign q_ext = {sgn_reg & inbus[WIDTH-1], inbus};

    always_comb begin
        sum = a_reg;
        case ({q_reg[0], qm_reg})
            2'b01:   sum = a_reg + m_reg;
            2'b10:   sum = a_reg + ~m_reg + ONE;
            default: sum = a_reg;
        endcase
    end

    // After WIDTH+1 iterations {a_reg, q_reg} holds the full product. The
    // top two bits are redundant sign/zero bits, so P is bits [2W-1:0].
    assign p_hi = {a_reg[WIDTH-2:0], q_reg[WIDTH]};
    assign p_lo = q_reg[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            m_reg     <= '0;
            a_reg     <= '0;
            q_reg     <= '0;
            qm_reg    <= 1'b0;
            cnt_reg   <= '0;
            sgn_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (enable) begin
                        m_reg     <= m_ext;
                        sgn_reg   <= is_signed;
                        state_reg <= S_LOAD_Q;
                    end
                end
                S_LOAD_Q: begin
                    q_reg     <= q_ext;
                    a_reg     <= '0;
                    qm_reg    <= 1'b0;
                    cnt_reg   <= '0;
                    state_reg <= S_RUN;
                end
                S_RUN: begin
                    // Arithmetic right shift of {sum, Q, Qm}.
                    a_reg   <= {sum[WIDTH], sum[WIDTH:1]};
                    q_reg   <= {sum[0], q_reg[WIDTH:1]};
                    qm_reg  <= q_reg[0];
                    cnt_reg <= cnt_reg + CNT_ONE;
                    if (cnt_reg == CNT_LAST) begin
                        state_reg <= S_OUT_HI;
                    end
                end
                S_OUT_HI: begin
                    if (out_ready) begin
                        state_reg <= S_OUT_LO;
                    end
                end
                S_OUT_LO: begin
                    if (out_ready) begin
                        state_reg <= S_IDLE;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign ready     = (state_reg == S_IDLE);
    assign out_valid = (state_reg == S_OUT_HI) || (state_reg == S_OUT_LO);
    assign out_hi    = (state_reg == S_OUT_HI);
    assign done      = done_reg;

    always_comb begin
        outbus = '0;
        if (state_reg == S_OUT_HI) begin
            outbus = p_hi;
        end else if (state_reg == S_OUT_LO) begin
            outbus = p_lo;
        end
    end

endmodule

// File: tb/tb_booth_mult_n.sv
// Testbench for booth_mult_n. Two instances (WIDTH=8 and WIDTH=16) share
// the clock and reset. Each instance has its own expected-beat queue, and a
// monitor compares beats against the queue head.
module tb_booth_mult_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  en;
    logic [1:0]  sg;
    logic [1:0]  ord;
    logic [31:0] ib [2];
    wire  [1:0]  rdy;
    wire  [1:0]  ov;
    wire  [1:0]  oh;
    wire  [1:0]  dn;
    wire  [7:0]  ob8;
    wire  [15:0] ob16;

    booth_mult_n #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (en[0]),
        .is_signed (sg[0]),
        .inbus     (ib[0][7:0]),
        .ready     (rdy[0]),
        .out_valid (ov[0]),
        .out_ready (ord[0]),
        .out_hi    (oh[0]),
        .outbus    (ob8),
        .done      (dn[0])
    );

    booth_mult_n #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (en[1]),
        .is_signed (sg[1]),
        .inbus     (ib[1][15:0]),
        .ready     (rdy[1]),
        .out_valid (ov[1]),
        .out_ready (ord[1]),
        .out_hi    (oh[1]),
        .outbus    (ob16),
        .done      (dn[1])
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [32:0] q0 [$];
    logic [32:0] q1 [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] obus(input int idx);
        return (idx == 0) ? {24'b0, ob8} : {16'b0, ob16};
    endfunction

    // Monitor: compares every presented beat with the queue head and pops it
    // on handshake. It also checks that outbus is idle-zero and that done
    // pulses exactly one cycle after the low beat is accepted.
    initial begin : monitor
        logic [1:0]  done_pend;
        logic [32:0] fr;
        logic        hs_lo;
        bit          empty;
        done_pend = 2'b00;
        forever begin
            @(negedge clk);
            for (int idx = 0; idx < 2; idx++) begin
                hs_lo = 1'b0;
                check($sformatf("done%0d", idx), 32'(dn[idx]), 32'(done_pend[idx]));
                if (ov[idx]) begin
                    empty = (idx == 0) ? (q0.size() == 0) : (q1.size() == 0);
                    if (empty) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_beat%0d: got 0x%0h hi=%0d, required no beat",
                                 idx, obus(idx), oh[idx]);
                    end else begin
                        fr = (idx == 0) ? q0[0] : q1[0];
                        check($sformatf("out_hi%0d", idx), 32'(oh[idx]), 32'(fr[32]));
                        check($sformatf("beat%0d", idx), obus(idx), fr[31:0]);
                        if (ord[idx]) begin
                            if (idx == 0) void'(q0.pop_front());
                            else          void'(q1.pop_front());
                            hs_lo = ~fr[32];
                        end
                        if (fr[32] == 1'b0 && ord[idx])
                            $display("[TB] dut%0d product beat lo 0x%0h accepted", idx, fr[31:0]);
                    end
                end else begin
                    check($sformatf("idle_zero%0d", idx), obus(idx), 32'h0);
                end
                done_pend[idx] = rst_n & hs_lo;
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_ready", 32'(rdy), 32'h3);
        check("rst_valid", 32'(ov), 32'h0);
        check("rst_hi", 32'(oh), 32'h0);
        check("rst_bus8", 32'(ob8), 32'h0);
        check("rst_bus16", 32'(ob16), 32'h0);
        check("rst_done", 32'(dn), 32'h0);
    endtask

    // Issue one multiply. If abort_at is nonzero, reset is pulled low at that
    // cycle after enable and no result is expected.
    task automatic run_op(input int idx, input logic s, input logic [31:0] m,
                          input logic [31:0] q, input logic [31:0] exp,
                          input int stall, input bit noise, input int abort_at);
        int          w;
        int          cyc;
        bit          rbad;
        logic [31:0] mask;
        w    = (idx == 0) ? 8 : 16;
        mask = (32'h1 << w) - 32'h1;
        cyc  = 0;
        while (!rdy[idx] && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("ready_wait", 32'(rdy[idx]), 32'h1);
        if (abort_at == 0) begin
            if (idx == 0) begin
                q0.push_back({1'b1, (exp >> w) & mask});
                q0.push_back({1'b0, exp & mask});
            end else begin
                q1.push_back({1'b1, (exp >> w) & mask});
                q1.push_back({1'b0, exp & mask});
            end
        end
        $display("[TB] dut%0d start %s 0x%0h * 0x%0h expect 0x%0h%s", idx,
                 s ? "signed" : "unsigned", m, q, exp, (abort_at != 0) ? " (aborted)" : "");
        ord[idx] = (stall == 0);
        en[idx]  = 1'b1;
        sg[idx]  = s;
        ib[idx]  = m;
        cyc  = 0;
        rbad = 0;
        while (cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                en[idx] = 1'b0;
                ib[idx] = q;
                sg[idx] = ~s;
            end
            if (abort_at != 0 && cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs();
                break;
            end
            if (ov[idx]) break;
            if (rdy[idx]) rbad = 1;
            if (noise && cyc >= 2) begin
                en[idx] = 1'($urandom);
                sg[idx] = 1'($urandom);
                ib[idx] = $urandom;
            end
        end
        en[idx] = 1'b0;
        if (abort_at != 0) begin
            @(posedge clk); #1;
            rst_n = 1'b1;
            return;
        end
        check("latency", 32'(cyc), 32'(w + 3));
        check("ready_low_busy", 32'(rbad), 32'h0);
        if (stall == 0) begin
            @(posedge clk); #1;
            check("lo_next_cycle", {30'b0, ov[idx], oh[idx]}, 32'h2);
        end else begin
            repeat (stall - 1) begin
                @(posedge clk); #1;
            end
            ord[idx] = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 2'b00;
        sg    = 2'b00;
        ord   = 2'b11;
        ib[0] = 32'h0;
        ib[1] = 32'h0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_op(0, 1'b1, 32'hFD,   32'h05,   32'h0000FFF1, 0, 0, 0);
        run_op(0, 1'b0, 32'hFF,   32'hFF,   32'h0000FE01, 0, 0, 0);
        run_op(0, 1'b1, 32'h80,   32'h80,   32'h00004000, 0, 0, 0);
        run_op(0, 1'b0, 32'h03,   32'h07,   32'h00000015, 5, 0, 0);
        run_op(0, 1'b0, 32'h02,   32'h02,   32'h00000004, 0, 0, 5);
        run_op(0, 1'b0, 32'h02,   32'h02,   32'h00000004, 0, 0, 0);
        run_op(0, 1'b1, 32'h7F,   32'h81,   32'h0000C0FF, 0, 1, 0);
        run_op(0, 1'b1, 32'hFF,   32'hFF,   32'h00000001, 0, 0, 0);
        run_op(0, 1'b0, 32'hFD,   32'h05,   32'h000004F1, 0, 0, 0);
        run_op(1, 1'b1, 32'h8000, 32'h7FFF, 32'hC0008000, 0, 0, 0);
        run_op(1, 1'b0, 32'hFFFF, 32'h0002, 32'h0001FFFE, 0, 0, 0);

        repeat (10) @(posedge clk);
        #1;
        check("q0_drained", 32'(q0.size()), 32'h0);
        check("q1_drained", 32'(q1.size()), 32'h0);
        check("final_ready", 32'(rdy), 32'h3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
